// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared encodings and default sizes for the MEM-stage load/store unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_HALF = 1'b1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RMW  = 1'b1
   } lsu_state_e;

   localparam int LSU_MEM_BYTES = 64;
   localparam int LSU_PROT_TOP  = 4;

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// lsu_load_align : selects and extends load data from the raw dm read word
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] dout,
   input  logic              size,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = dout;
      if (size == SZ_BYTE) begin
         if (sign_ext) begin
            data = {{(DATA_W-8){dout[7]}}, dout[7:0]};
         end else begin
            data = {{(DATA_W-8){1'b0}}, dout[7:0]};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit; byte stores via read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN makes odd-address halfword accesses fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MEM_BYTES = LSU_MEM_BYTES,
   parameter int PROT_TOP  = LSU_PROT_TOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   input  logic [DATA_W-1:0] dm_dout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
   localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_TOP);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
   logic [7:0]        rmw_byte_q, rmw_byte_d;
   logic [7:0]        rmw_hi_q, rmw_hi_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

   logic              misaligned;
   logic              illegal;
   logic [DATA_W-1:0] load_data;

   lsu_load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .dout     (dm_dout),
      .size     (req_size),
      .sign_ext (req_signed),
      .data     (load_data)
   );

   always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
      misaligned = (req_size == SZ_HALF) && req_addr[0];
`else
      misaligned = 1'b0;
`endif
      illegal = (req_addr >= LAST_ADDR) || (req_we && (req_addr <= PROT_ADDR)) || misaligned;
   end

   always_comb begin
      state_d      = state_q;
      rmw_addr_d   = rmw_addr_q;
      rmw_byte_d   = rmw_byte_q;
      rmw_hi_d     = rmw_hi_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      fault_d      = 1'b0;
      fault_addr_d = fault_addr_q;
      dm_we        = 1'b0;
      dm_addr      = req_addr;
      dm_din       = req_wdata;

      if (state_q == RMW) begin
         // Second half of a byte store: merge the new byte with the old upper byte.
         dm_we   = 1'b1;
         dm_addr = rmw_addr_q;
         dm_din  = DATA_W'({rmw_hi_q, rmw_byte_q});
         state_d = IDLE;
      end else if (req_valid) begin
         if (illegal) begin
            fault_d      = 1'b1;
            fault_addr_d = req_addr;
            if (!req_we) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
            end
         end else if (!req_we) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
         end else if (req_size == SZ_HALF) begin
            dm_we = 1'b1;
         end else begin
            rmw_addr_d = req_addr;
            rmw_byte_d = req_wdata[7:0];
            rmw_hi_d   = dm_dout[15:8];
            state_d    = RMW;
         end
      end

      if (rst) begin
         dm_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rmw_addr_q   <= '0;
         rmw_byte_q   <= '0;
         rmw_hi_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         rmw_addr_q   <= rmw_addr_d;
         rmw_byte_q   <= rmw_byte_d;
         rmw_hi_q     <= rmw_hi_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign stall      = (state_q == RMW);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu : directed and randomized checks of mem_stage_lsu against
// a byte-array reference model; also models the little-endian dm.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_size, req_signed;
   logic [15:0] req_addr, req_wdata;
   logic        stall, resp_valid, fault, dm_we;
   logic [15:0] resp_rdata, fault_addr, dm_addr, dm_din, dm_dout;

   int checks = 0;
   int errors = 0;
   int we_count = 0;

   logic [7:0] dm_mem [64];
   logic [7:0] ref_mem [64];
   bit          prev_bs;
   logic [15:0] exp_faddr;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .fault      (fault),
      .fault_addr (fault_addr),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_din     (dm_din),
      .dm_dout    (dm_dout)
   );

   // little-endian dm: combinational read, 16-bit write at the clock edge
   assign dm_dout = {dm_mem[dm_addr[5:0] + 6'd1], dm_mem[dm_addr[5:0]]};

   always @(posedge clk) begin
      if (dm_we) begin
         dm_mem[dm_addr[5:0]]        <= dm_din[7:0];
         dm_mem[dm_addr[5:0] + 6'd1] <= dm_din[15:8];
         we_count++;
      end
   end

   // Reference: applies the access rules directly to a byte array.
   task automatic ref_step(input logic we, input logic sz, input logic sg,
                           input logic [15:0] a, input logic [15:0] wd,
                           output logic rv, output logic [15:0] rd,
                           output logic flt, output int st);
      bit         bad;
      logic [7:0] lo, hi;
      int         ia;
      st  = prev_bs ? 1 : 0;
      bad = (int'(a) >= 63) || (we && int'(a) <= 4);
`ifdef LSU_ALIGN_CHECK_EN
      if (sz && (a % 2 == 1)) bad = 1;
`endif
      prev_bs = 0;
      rv = 0; rd = 0; flt = 0;
      ia = int'(a) % 64;
      if (bad) begin
         flt = 1;
         rv = !we;
         exp_faddr = a;
      end else if (!we) begin
         rv = 1;
         lo = ref_mem[ia];
         hi = ref_mem[(ia + 1) % 64];
         if (sz) rd = 16'(int'(hi) * 256 + int'(lo));
         else if (sg) rd = 16'($signed(lo));
         else rd = 16'(lo);
      end else begin
         ref_mem[ia] = wd[7:0];
         if (sz) ref_mem[(ia + 1) % 64] = wd[15:8];
         else prev_bs = 1;
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance with the response.
   task automatic do_req(input logic we, input logic sz, input logic sg,
                         input logic [15:0] a, input logic [15:0] wd,
                         output logic rv, output logic [15:0] rd, output logic flt,
                         output logic [15:0] fa, output int stalls);
      req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      stalls = 0;
      while (stall && stalls < 8) begin
         @(posedge clk); @(negedge clk);
         stalls++;
      end
      if (stalls >= 8) begin
         checks++; errors++;
         $display("FAIL stall_timeout: addr=%h still stalled after %0d cycles, want release", a, stalls);
      end
      @(posedge clk); @(negedge clk);
      rv = resp_valid; rd = resp_rdata; flt = fault; fa = fault_addr;
      req_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1; req_valid = 1; req_we = 1; req_size = 1; req_signed = 0;
      req_addr = 16'h0010; req_wdata = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (dm_we !== 1'b0) begin
            errors++; $display("FAIL reset_dm_we: dm_we=%b, want 0", dm_we);
         end
      end
      req_valid = 0;
      @(negedge clk);
      rst = 0;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || fault !== 1'b0 ||
          fault_addr !== 16'h0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rv=%b rd=%h flt=%b fa=%h stall=%b, want 0 0000 0 0000 0",
                  resp_valid, resp_rdata, fault, fault_addr, stall);
      end
   endtask

   task automatic test_id_loads();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd; int st, est;
      ref_step(0, 1, 0, 16'h0000, 16'h0, erv, erd, eflt, est);
      do_req(0, 1, 0, 16'h0000, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (rv !== 1'b1 || rd !== 16'h0212 || flt !== 1'b0) begin
         errors++; $display("FAIL id_half: rv=%b rd=%h flt=%b, want 1 0212 0", rv, rd, flt);
      end
      ref_step(0, 0, 1, 16'h0003, 16'h0, erv, erd, eflt, est);
      do_req(0, 0, 1, 16'h0003, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (rv !== 1'b1 || rd !== 16'h0020 || flt !== 1'b0) begin
         errors++; $display("FAIL id_sbyte: rv=%b rd=%h flt=%b, want 1 0020 0", rv, rd, flt);
      end
   endtask

   task automatic test_byte_store();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd; int st, est;
      ref_step(1, 0, 0, 16'h0006, 16'h55AB, erv, erd, eflt, est);
      do_req(1, 0, 0, 16'h0006, 16'h55AB, rv, rd, flt, fa, st);
      checks++;
      if (rv !== 1'b0 || flt !== 1'b0 || st !== 0) begin
         errors++; $display("FAIL bstore_accept: rv=%b flt=%b stalls=%0d, want 0 0 0", rv, flt, st);
      end
      ref_step(0, 1, 0, 16'h0006, 16'h0, erv, erd, eflt, est);
      do_req(0, 1, 0, 16'h0006, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (st !== 1 || rv !== 1'b1 || rd !== 16'h00AB) begin
         errors++; $display("FAIL bstore_load: stalls=%0d rv=%b rd=%h, want 1 1 00ab", st, rv, rd);
      end
      checks++;
      if (dm_mem[7] !== 8'h00) begin
         errors++; $display("FAIL bstore_upper: mem[7]=%h, want 00", dm_mem[7]);
      end
   endtask

   task automatic test_sign_ext();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd; int st, est;
      ref_step(1, 0, 0, 16'h0008, 16'h00F0, erv, erd, eflt, est);
      do_req(1, 0, 0, 16'h0008, 16'h00F0, rv, rd, flt, fa, st);
      ref_step(0, 0, 1, 16'h0008, 16'h0, erv, erd, eflt, est);
      do_req(0, 0, 1, 16'h0008, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (st !== 1 || rd !== 16'hFFF0) begin
         errors++; $display("FAIL sbyte_load: stalls=%0d rd=%h, want 1 fff0", st, rd);
      end
      ref_step(0, 0, 0, 16'h0008, 16'h0, erv, erd, eflt, est);
      do_req(0, 0, 0, 16'h0008, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (st !== 0 || rd !== 16'h00F0) begin
         errors++; $display("FAIL ubyte_load: stalls=%0d rd=%h, want 0 00f0", st, rd);
      end
   endtask

   task automatic test_protect_range();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd; int st, est, c0;
      c0 = we_count;
      ref_step(1, 1, 0, 16'h0002, 16'hBEEF, erv, erd, eflt, est);
      do_req(1, 1, 0, 16'h0002, 16'hBEEF, rv, rd, flt, fa, st);
      checks++;
      if (flt !== 1'b1 || fa !== 16'h0002 || rv !== 1'b0 || we_count !== c0) begin
         errors++; $display("FAIL protect_store: flt=%b fa=%h rv=%b writes=%0d, want 1 0002 0 0",
                            flt, fa, rv, we_count - c0);
      end
      ref_step(0, 1, 0, 16'h0002, 16'h0, erv, erd, eflt, est);
      do_req(0, 1, 0, 16'h0002, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (rd !== 16'h2022 || flt !== 1'b0 || fa !== 16'h0002) begin
         errors++; $display("FAIL protect_load: rd=%h flt=%b fa=%h, want 2022 0 0002", rd, flt, fa);
      end
      ref_step(0, 1, 0, 16'h003F, 16'h0, erv, erd, eflt, est);
      do_req(0, 1, 0, 16'h003F, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (rv !== 1'b1 || rd !== 16'h0000 || flt !== 1'b1 || fa !== 16'h003F) begin
         errors++; $display("FAIL range_load: rv=%b rd=%h flt=%b fa=%h, want 1 0000 1 003f",
                            rv, rd, flt, fa);
      end
   endtask

   task automatic test_reset_in_rmw();
      logic rv, flt; logic [15:0] rd, fa; int st, c0;
      c0 = we_count;
      do_req(1, 0, 0, 16'h000A, 16'h005A, rv, rd, flt, fa, st);
      rst = 1;
      @(posedge clk); @(negedge clk);
      rst = 0;
      prev_bs = 0;
      exp_faddr = 16'h0;
      checks++;
      if (we_count !== c0 || dm_mem[10] !== 8'h00 || stall !== 1'b0) begin
         errors++; $display("FAIL rst_rmw: writes=%0d mem[0a]=%h stall=%b, want 0 00 0",
                            we_count - c0, dm_mem[10], stall);
      end
   endtask

   task automatic test_odd_half();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd; int st, est;
      ref_step(0, 1, 0, 16'h0005, 16'h0, erv, erd, eflt, est);
      do_req(0, 1, 0, 16'h0005, 16'h0, rv, rd, flt, fa, st);
      checks++;
      if (rv !== erv || rd !== erd || flt !== eflt) begin
         errors++; $display("FAIL odd_half: rv=%b rd=%h flt=%b, want %b %h %b", rv, rd, flt, erv, erd, eflt);
      end
   endtask

   task automatic test_back_to_back();
      logic rv, flt, erv, eflt; logic [15:0] rd, fa, erd, a, wd; int st, est;
      logic [15:0] addrs [4];
      for (int i = 0; i < 4; i++) begin
         addrs[i] = 16'(16 + 8 * i + $urandom_range(0, 1));
         wd = 16'($urandom);
         ref_step(1, 1, 0, addrs[i], wd, erv, erd, eflt, est);
         do_req(1, 1, 0, addrs[i], wd, rv, rd, flt, fa, st);
         checks++;
         if (st !== 0 || flt !== eflt) begin
            errors++; $display("FAIL b2b_store: stalls=%0d flt=%b, want 0 %b", st, flt, eflt);
         end
      end
      for (int i = 0; i < 4; i++) begin
         a = addrs[i];
         ref_step(0, 1, 0, a, 16'h0, erv, erd, eflt, est);
         do_req(0, 1, 0, a, 16'h0, rv, rd, flt, fa, st);
         checks++;
         if (st !== 0 || rv !== erv || rd !== erd) begin
            errors++; $display("FAIL b2b_load: addr=%h stalls=%0d rv=%b rd=%h, want 0 %b %h",
                               a, st, rv, rd, erv, erd);
         end
      end
   endtask

   task automatic test_random();
      logic rv, flt, erv, eflt, we, sz, sg; logic [15:0] rd, fa, erd, a, wd; int st, est;
      for (int i = 0; i < 120; i++) begin
         we = 1'($urandom); sz = 1'($urandom); sg = 1'($urandom);
         wd = 16'($urandom);
         if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(63, 65535));
         else a = 16'($urandom_range(0, 61));
         ref_step(we, sz, sg, a, wd, erv, erd, eflt, est);
         do_req(we, sz, sg, a, wd, rv, rd, flt, fa, st);
         checks++;
         if (rv !== erv || flt !== eflt || st !== est || fa !== exp_faddr ||
             (erv && rd !== erd)) begin
            errors++;
            $display("FAIL random[%0d]: we=%b sz=%b sg=%b a=%h got rv=%b rd=%h flt=%b fa=%h st=%0d want %b %h %b %h %0d",
                     i, we, sz, sg, a, rv, rd, flt, fa, st, erv, erd, eflt, exp_faddr, est);
         end
      end
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (dm_mem[i] !== ref_mem[i]) begin
            errors++; $display("FAIL mem_final[%0d]: got %h, want %h", i, dm_mem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         dm_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      dm_mem[0] = 8'h12; dm_mem[1] = 8'h02; dm_mem[2] = 8'h22; dm_mem[3] = 8'h20; dm_mem[4] = 8'h4D;
      for (int i = 0; i < 5; i++) ref_mem[i] = dm_mem[i];
      prev_bs = 0;
      exp_faddr = 16'h0;
      req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
      req_addr = 16'h0; req_wdata = 16'h0;

      test_reset();
      test_id_loads();
      test_byte_store();
      test_sign_ext();
      test_protect_range();
      test_reset_in_rmw();
      test_odd_half();
      test_back_to_back();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
